mcu_port_controller: RTL and testbench
======================================

// Module: mcu_port_controller
// PURPOSE
// - MCU-facing register port onto the pixel memory arbiter; next generation of the MCU interface.
// - Parametrised coordinate/data widths; 2-D auto-increment box with X and Y wrap.
// - Posted-write FIFO that decouples MCU bus cycles from memory latency.
// - MCU readback of pixels, plus a status register.
// PARAMETERS
// X_WIDTH     9  memory X coordinate width
// Y_WIDTH     8  memory Y coordinate width
// DATA_WIDTH  8  pixel / MCU bus width (>= 5, <= 8)
// FIFO_DEPTH  4  posted-write entries, power of two, >= 2
// PORTS
// clock                clock      input   1           system clock
// reset                reset      input   1           asynchronous, active-high
// mpuChipSelect        mcu bus    input   1           high = bus cycle in progress
// mpuWriteEnable       mcu bus    input   1           low = MCU write, high = MCU read
// mpuRegisterSelect    mcu bus    input   3           register index
// mpuDataIn            mcu bus    input   DATA_WIDTH  write data
// mpuDataOut           mcu bus    output  DATA_WIDTH  read data, combinational from registers
// mpuDataOutEnable     mcu bus    output  1           = mpuChipSelect && mpuWriteEnable
// memoryXCoord         memory     output  X_WIDTH     access X coordinate
// memoryYCoord         memory     output  Y_WIDTH     access Y coordinate
// memoryWriteRequest   memory     output  1           write request, level
// memoryWriteData      memory     output  DATA_WIDTH  write data
// memoryReadRequest    memory     output  1           read request, level
// memoryReadData       memory     input   DATA_WIDTH  read data, valid with complete
// memoryWriteComplete  memory     input   1           one-cycle write acknowledge
// memoryReadComplete   memory     input   1           one-cycle read acknowledge
// BEHAVIOUR
// Bus access and register map
// - Exactly one access per chip-select assertion: action on the first clock with CS high; re-armed when CS drops.
// - Register map:
//   0 X_LOW; 1 X_HIGH (bits X_WIDTH-1:8); 2 Y; 3 DATA; 4 BOX_CTRL; 5 BOX_DATA; 6 READ_REQ; 7 STATUS (read-only).
// Writes
// - DATA: push {x, y, data} into the FIFO, then advance the cursor.
// - BOX_CTRL: 0 disables the box; nonzero enables the box and resets the BOX_DATA index to 0.
// - BOX_DATA: sequence xStart lo/hi, xStop lo/hi, yStart, yStop; the index increments per write and saturates.
// - READ_REQ: any write posts a read at the current cursor, then advances the cursor; clears readValid.
// Reads
// - DATA: returns readData; readValid clears at the end of the access.
// - STATUS: {.., overflow[4], boxEn[3], readValid[2], fifoEmpty[1], fifoFull[0]}; overflow clears at the end of the read.
// - Any other register reads its held value.
// Cursor advance (box enabled only; otherwise the cursor holds)
// - If x == xStop: x <= xStart; y <= (y == yStop) ? yStart : y + 1.
// - Otherwise: x <= x + 1.
// - Arithmetic is modulo 2^W.
// FIFO
// - A DATA write while the FIFO is full is dropped; overflow sets and the cursor still advances.
// - A push and a pop on the same cycle are both honoured.
// Memory FSM (IDLE, WRITE, READ)
// - IDLE -> WRITE when the FIFO is not empty: drive the head entry and set memoryWriteRequest.
// - WRITE: hold the request until memoryWriteComplete; drop the request and pop the FIFO on that cycle; go to IDLE.
// - IDLE -> READ when a read is pending AND the FIFO is empty: reads never pass posted writes.
// - READ: hold memoryReadRequest until memoryReadComplete; latch readData; set readValid; go to IDLE.
// - Back-to-back requests are separated by at least one idle cycle.
// Reset
// - All outputs 0; cursor, box bounds and readData 0; boxEn 0; FIFO empty; flags 0; FSM IDLE.
// - A mid-transaction reset abandons the request immediately; a late complete is ignored in IDLE.
// STRUCTURE
// - Package mcu_port_pkg: register index localparams, STATUS bit indices, memory FSM state enum, box-index enum.
// - Sub-module mcu_write_fifo (parametrised width/depth; push, pop, head, full, empty); holds {x, y, data}.
// TESTING
// 1 Reset: assert reset -> all outputs 0 and STATUS = 8'h02.
// 2 Single write: X=5, Y=7, write DATA 8'hAA, write complete after 3 cycles
//   -> one write request at (5,7,AA), held 3 cycles, then FIFO empty.
// 3 Box wrap: box x 2..3, y 10..11, cursor (2,10); 5 DATA writes
//   -> addresses (2,10) (3,10) (2,11) (3,11) (2,10).
// 4 Overflow: stall write complete; 5 DATA writes with depth 4
//   -> 4 queued, STATUS bit4 = 1; a STATUS read clears it.
// 5 Read ordering: two DATA writes then READ_REQ -> read issued only after the second write completes;
//   memoryReadData = 8'h3C -> STATUS bit2 = 1, DATA reads 8'h3C, then bit2 = 0.
// 6 Reset mid-write: reset while the write request is high
//   -> request drops asynchronously, FIFO empty, and a subsequent complete has no effect.

Source files
------------

// File: rtl/mcu_port_pkg.sv
// Shared definitions for the MCU port controller: register map, STATUS bit
// positions, memory FSM states and the BOX_DATA write sequence.
package mcu_port_pkg;

  // MCU register indices
  localparam logic [2:0] REG_X_LOW    = 3'd0;
  localparam logic [2:0] REG_X_HIGH   = 3'd1;
  localparam logic [2:0] REG_Y        = 3'd2;
  localparam logic [2:0] REG_DATA     = 3'd3;
  localparam logic [2:0] REG_BOX_CTRL = 3'd4;
  localparam logic [2:0] REG_BOX_DATA = 3'd5;
  localparam logic [2:0] REG_READ_REQ = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  // STATUS bit positions
  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_RVALID = 2;
  localparam int unsigned ST_BOXEN  = 3;
  localparam int unsigned ST_OVF    = 4;
  localparam int unsigned STATUS_W  = 5;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2
  } mem_state_e;

  // Which box bound the next BOX_DATA write lands in; BOX_DONE absorbs extras.
  typedef enum logic [2:0] {
    BOX_XSTART_LO = 3'd0,
    BOX_XSTART_HI = 3'd1,
    BOX_XSTOP_LO  = 3'd2,
    BOX_XSTOP_HI  = 3'd3,
    BOX_YSTART    = 3'd4,
    BOX_YSTOP     = 3'd5,
    BOX_DONE      = 3'd6
  } box_idx_e;

  // Saturating step through the BOX_DATA sequence.
  function automatic box_idx_e box_idx_next(input box_idx_e idx);
    box_idx_e nxt;
    case (idx)
      BOX_XSTART_LO: nxt = BOX_XSTART_HI;
      BOX_XSTART_HI: nxt = BOX_XSTOP_LO;
      BOX_XSTOP_LO:  nxt = BOX_XSTOP_HI;
      BOX_XSTOP_HI:  nxt = BOX_YSTART;
      BOX_YSTART:    nxt = BOX_YSTOP;
      BOX_YSTOP:     nxt = BOX_DONE;
      BOX_DONE:      nxt = BOX_DONE;
      default:       nxt = BOX_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mcu_write_fifo.sv
// Posted-write FIFO: holds {x, y, data} entries between the MCU bus and the
// memory FSM. Push while full is ignored; push and pop may coincide.
module mcu_write_fifo
  import mcu_port_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next storage, pointers and occupancy from the push/pop requests.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mcu_port_controller.sv
// MCU register port onto the pixel memory arbiter: cursor with 2-D box
// auto-increment, posted-write FIFO, pixel readback and STATUS.
// X_WIDTH is expected in 9..16 (X_LOW holds bits 7:0), DATA_WIDTH in 5..8.
module mcu_port_controller
  import mcu_port_pkg::*;
#(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mpuChipSelect,
  input  logic                  mpuWriteEnable,
  input  logic [2:0]            mpuRegisterSelect,
  input  logic [DATA_WIDTH-1:0] mpuDataIn,
  output logic [DATA_WIDTH-1:0] mpuDataOut,
  output logic                  mpuDataOutEnable,
  output logic [X_WIDTH-1:0]    memoryXCoord,
  output logic [Y_WIDTH-1:0]    memoryYCoord,
  output logic                  memoryWriteRequest,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  output logic                  memoryReadRequest,
  input  logic [DATA_WIDTH-1:0] memoryReadData,
  input  logic                  memoryWriteComplete,
  input  logic                  memoryReadComplete
);

  localparam int ENTRY_W = X_WIDTH + Y_WIDTH + DATA_WIDTH;

  // Bus-side registers
  logic                  cs_prev_q, cs_prev_d;
  logic [X_WIDTH-1:0]    x_q, x_d, x_start_q, x_start_d, x_stop_q, x_stop_d;
  logic [Y_WIDTH-1:0]    y_q, y_d, y_start_q, y_start_d, y_stop_q, y_stop_d;
  logic                  box_en_q, box_en_d;
  box_idx_e              box_idx_q, box_idx_d;
  logic                  overflow_q, overflow_d;
  logic                  read_valid_q, read_valid_d;
  logic                  read_pending_q, read_pending_d;
  logic [X_WIDTH-1:0]    rd_x_q, rd_x_d;
  logic [Y_WIDTH-1:0]    rd_y_q, rd_y_d;
  logic                  clr_rv_q, clr_rv_d;
  logic                  clr_ovf_q, clr_ovf_d;

  // Memory-side registers
  mem_state_e            state_q, state_d;
  logic                  wr_req_q, wr_req_d;
  logic                  rd_req_q, rd_req_d;
  logic [X_WIDTH-1:0]    mem_x_q, mem_x_d;
  logic [Y_WIDTH-1:0]    mem_y_q, mem_y_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  // Combinational helpers
  logic                  access_s, wr_access_s, rd_access_s, cs_fall_s;
  logic [7:0]            din8_s, rd8_s;
  logic [X_WIDTH-1:0]    adv_x_s;
  logic [Y_WIDTH-1:0]    adv_y_s;
  logic                  fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic                  ovf_set_s, read_issue_s, read_done_s;
  logic [ENTRY_W-1:0]    fifo_head_s;
  logic [X_WIDTH-1:0]    head_x_s;
  logic [Y_WIDTH-1:0]    head_y_s;
  logic [DATA_WIDTH-1:0] head_d_s;
  logic [STATUS_W-1:0]   status_s;

  // One access per chip-select assertion: act only on its first clock.
  assign access_s    = mpuChipSelect && !cs_prev_q;
  assign wr_access_s = access_s && !mpuWriteEnable;
  assign rd_access_s = access_s && mpuWriteEnable;
  assign cs_fall_s   = cs_prev_q && !mpuChipSelect;
  assign din8_s      = 8'(mpuDataIn);

  assign fifo_push_s = wr_access_s && (mpuRegisterSelect == REG_DATA) && !fifo_full_s;
  assign ovf_set_s   = wr_access_s && (mpuRegisterSelect == REG_DATA) && fifo_full_s;

  assign status_s[ST_FULL]   = fifo_full_s;
  assign status_s[ST_EMPTY]  = fifo_empty_s;
  assign status_s[ST_RVALID] = read_valid_q;
  assign status_s[ST_BOXEN]  = box_en_q;
  assign status_s[ST_OVF]    = overflow_q;

  assign {head_x_s, head_y_s, head_d_s} = fifo_head_s;

  mcu_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_write_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data ({x_q, y_q, din8_s[DATA_WIDTH-1:0]}),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Cursor position after one box step (X wraps to xStart, Y wraps to yStart).
  always_comb begin
    adv_x_s = x_q;
    adv_y_s = y_q;
    if (x_q == x_stop_q) begin
      adv_x_s = x_start_q;
      if (y_q == y_stop_q) begin
        adv_y_s = y_start_q;
      end else begin
        adv_y_s = y_q + Y_WIDTH'(1);
      end
    end else begin
      adv_x_s = x_q + X_WIDTH'(1);
      adv_y_s = y_q;
    end
  end

  // Bus register updates: cursor, box, flags and deferred end-of-access clears.
  always_comb begin
    cs_prev_d      = mpuChipSelect;
    x_d            = x_q;
    y_d            = y_q;
    x_start_d      = x_start_q;
    x_stop_d       = x_stop_q;
    y_start_d      = y_start_q;
    y_stop_d       = y_stop_q;
    box_en_d       = box_en_q;
    box_idx_d      = box_idx_q;
    rd_x_d         = rd_x_q;
    rd_y_d         = rd_y_q;

    // New events win over clears that fall due on the same cycle.
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (cs_fall_s && clr_ovf_q) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (wr_access_s && (mpuRegisterSelect == REG_READ_REQ)) begin
      read_valid_d = 1'b0;
    end else if (read_done_s) begin
      read_valid_d = 1'b1;
    end else if (cs_fall_s && clr_rv_q) begin
      read_valid_d = 1'b0;
    end else begin
      read_valid_d = read_valid_q;
    end

    if (wr_access_s && (mpuRegisterSelect == REG_READ_REQ)) begin
      read_pending_d = 1'b1;
    end else if (read_issue_s) begin
      read_pending_d = 1'b0;
    end else begin
      read_pending_d = read_pending_q;
    end

    if (rd_access_s && (mpuRegisterSelect == REG_DATA)) begin
      clr_rv_d = 1'b1;
    end else if (cs_fall_s) begin
      clr_rv_d = 1'b0;
    end else begin
      clr_rv_d = clr_rv_q;
    end

    if (rd_access_s && (mpuRegisterSelect == REG_STATUS)) begin
      clr_ovf_d = 1'b1;
    end else if (cs_fall_s) begin
      clr_ovf_d = 1'b0;
    end else begin
      clr_ovf_d = clr_ovf_q;
    end

    if (wr_access_s) begin
      case (mpuRegisterSelect)
        REG_X_LOW:  x_d = {x_q[X_WIDTH-1:8], din8_s};
        REG_X_HIGH: x_d = {din8_s[X_WIDTH-9:0], x_q[7:0]};
        REG_Y:      y_d = Y_WIDTH'(din8_s);
        REG_DATA, REG_READ_REQ: begin
          if (box_en_q) begin
            x_d = adv_x_s;
            y_d = adv_y_s;
          end else begin
            x_d = x_q;
            y_d = y_q;
          end
          if (mpuRegisterSelect == REG_READ_REQ) begin
            rd_x_d = x_q;
            rd_y_d = y_q;
          end else begin
            rd_x_d = rd_x_q;
            rd_y_d = rd_y_q;
          end
        end
        REG_BOX_CTRL: begin
          if (|mpuDataIn) begin
            box_en_d  = 1'b1;
            box_idx_d = BOX_XSTART_LO;
          end else begin
            box_en_d  = 1'b0;
            box_idx_d = box_idx_q;
          end
        end
        REG_BOX_DATA: begin
          box_idx_d = box_idx_next(box_idx_q);
          case (box_idx_q)
            BOX_XSTART_LO: x_start_d = {x_start_q[X_WIDTH-1:8], din8_s};
            BOX_XSTART_HI: x_start_d = {din8_s[X_WIDTH-9:0], x_start_q[7:0]};
            BOX_XSTOP_LO:  x_stop_d  = {x_stop_q[X_WIDTH-1:8], din8_s};
            BOX_XSTOP_HI:  x_stop_d  = {din8_s[X_WIDTH-9:0], x_stop_q[7:0]};
            BOX_YSTART:    y_start_d = Y_WIDTH'(din8_s);
            BOX_YSTOP:     y_stop_d  = Y_WIDTH'(din8_s);
            default:       box_idx_d = BOX_DONE;
          endcase
        end
        default: x_d = x_q;
      endcase
    end else begin
      x_d = x_q;
    end
  end

  // Memory FSM: drain posted writes first, then service a pending read.
  always_comb begin
    state_d      = state_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    mem_x_d      = mem_x_q;
    mem_y_d      = mem_y_q;
    mem_wdata_d  = mem_wdata_q;
    read_data_d  = read_data_q;
    fifo_pop_s   = 1'b0;
    read_issue_s = 1'b0;
    read_done_s  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (!fifo_empty_s) begin
          state_d     = MEM_WRITE;
          wr_req_d    = 1'b1;
          mem_x_d     = head_x_s;
          mem_y_d     = head_y_s;
          mem_wdata_d = head_d_s;
        end else if (read_pending_q) begin
          state_d      = MEM_READ;
          rd_req_d     = 1'b1;
          mem_x_d      = rd_x_q;
          mem_y_d      = rd_y_q;
          read_issue_s = 1'b1;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_WRITE: begin
        if (memoryWriteComplete) begin
          state_d    = MEM_IDLE;
          wr_req_d   = 1'b0;
          fifo_pop_s = 1'b1;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      MEM_READ: begin
        if (memoryReadComplete) begin
          state_d     = MEM_IDLE;
          rd_req_d    = 1'b0;
          read_data_d = memoryReadData;
          read_done_s = 1'b1;
        end else begin
          state_d = MEM_READ;
        end
      end
      default: begin
        state_d  = MEM_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // Read-back mux: combinational view of the addressed register.
  always_comb begin
    case (mpuRegisterSelect)
      REG_X_LOW:    rd8_s = x_q[7:0];
      REG_X_HIGH:   rd8_s = 8'(x_q[X_WIDTH-1:8]);
      REG_Y:        rd8_s = 8'(y_q);
      REG_DATA:     rd8_s = 8'(read_data_q);
      REG_BOX_CTRL: rd8_s = 8'(box_en_q);
      REG_BOX_DATA: rd8_s = 8'(box_idx_q);
      REG_READ_REQ: rd8_s = 8'(read_pending_q);
      REG_STATUS:   rd8_s = 8'(status_s);
      default:      rd8_s = 8'h00;
    endcase
  end

  assign mpuDataOut         = rd8_s[DATA_WIDTH-1:0];
  assign mpuDataOutEnable   = mpuChipSelect && mpuWriteEnable;
  assign memoryXCoord       = mem_x_q;
  assign memoryYCoord       = mem_y_q;
  assign memoryWriteRequest = wr_req_q;
  assign memoryWriteData    = mem_wdata_q;
  assign memoryReadRequest  = rd_req_q;

  // State registers; reset abandons any memory request immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_prev_q      <= 1'b0;
      x_q            <= {X_WIDTH{1'b0}};
      y_q            <= {Y_WIDTH{1'b0}};
      x_start_q      <= {X_WIDTH{1'b0}};
      x_stop_q       <= {X_WIDTH{1'b0}};
      y_start_q      <= {Y_WIDTH{1'b0}};
      y_stop_q       <= {Y_WIDTH{1'b0}};
      box_en_q       <= 1'b0;
      box_idx_q      <= BOX_XSTART_LO;
      overflow_q     <= 1'b0;
      read_valid_q   <= 1'b0;
      read_pending_q <= 1'b0;
      rd_x_q         <= {X_WIDTH{1'b0}};
      rd_y_q         <= {Y_WIDTH{1'b0}};
      clr_rv_q       <= 1'b0;
      clr_ovf_q      <= 1'b0;
      state_q        <= MEM_IDLE;
      wr_req_q       <= 1'b0;
      rd_req_q       <= 1'b0;
      mem_x_q        <= {X_WIDTH{1'b0}};
      mem_y_q        <= {Y_WIDTH{1'b0}};
      mem_wdata_q    <= {DATA_WIDTH{1'b0}};
      read_data_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      cs_prev_q      <= cs_prev_d;
      x_q            <= x_d;
      y_q            <= y_d;
      x_start_q      <= x_start_d;
      x_stop_q       <= x_stop_d;
      y_start_q      <= y_start_d;
      y_stop_q       <= y_stop_d;
      box_en_q       <= box_en_d;
      box_idx_q      <= box_idx_d;
      overflow_q     <= overflow_d;
      read_valid_q   <= read_valid_d;
      read_pending_q <= read_pending_d;
      rd_x_q         <= rd_x_d;
      rd_y_q         <= rd_y_d;
      clr_rv_q       <= clr_rv_d;
      clr_ovf_q      <= clr_ovf_d;
      state_q        <= state_d;
      wr_req_q       <= wr_req_d;
      rd_req_q       <= rd_req_d;
      mem_x_q        <= mem_x_d;
      mem_y_q        <= mem_y_d;
      mem_wdata_q    <= mem_wdata_d;
      read_data_q    <= read_data_d;
    end
  end

endmodule

// File: tb/tb_mcu_port_controller.sv
// Scoreboard bench for mcu_port_controller: stimulus queues expected memory
// requests and MCU read values; a negedge monitor pops and compares them.
module tb_mcu_port_controller;
  import mcu_port_pkg::*;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int DW = 8;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mpuChipSelect = 1'b0;
  logic          mpuWriteEnable = 1'b1;
  logic [2:0]    mpuRegisterSelect = 3'd0;
  logic [DW-1:0] mpuDataIn = 8'h00;
  logic [DW-1:0] mpuDataOut;
  logic          mpuDataOutEnable;
  logic [XW-1:0] memoryXCoord;
  logic [YW-1:0] memoryYCoord;
  logic          memoryWriteRequest;
  logic [DW-1:0] memoryWriteData;
  logic          memoryReadRequest;
  logic [DW-1:0] memoryReadData = 8'h00;
  logic          memoryWriteComplete = 1'b0;
  logic          memoryReadComplete = 1'b0;

  always #5 clock = ~clock;

  mcu_port_controller #(.X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset),
    .mpuChipSelect(mpuChipSelect), .mpuWriteEnable(mpuWriteEnable),
    .mpuRegisterSelect(mpuRegisterSelect), .mpuDataIn(mpuDataIn),
    .mpuDataOut(mpuDataOut), .mpuDataOutEnable(mpuDataOutEnable),
    .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
    .memoryWriteRequest(memoryWriteRequest), .memoryWriteData(memoryWriteData),
    .memoryReadRequest(memoryReadRequest), .memoryReadData(memoryReadData),
    .memoryWriteComplete(memoryWriteComplete), .memoryReadComplete(memoryReadComplete)
  );

  typedef struct packed {
    logic          is_read;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
  } mreq_t;

  mreq_t         mem_exp_q[$];
  logic [DW-1:0] rd_exp_q[$];
  string         rd_name_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // memory responder controls
  int            wr_lat = 1;
  logic          stall = 1'b0;
  logic          manual_wc = 1'b0;
  logic [DW-1:0] rd_value = 8'h00;
  int            wcnt = 0;
  int            last_hold = 0;
  int            wr_hold = 0;
  logic          wr_prev = 1'b0;
  logic          rd_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [DW-1:0] d);
    mreq_t e;
    e.is_read = 1'b0; e.x = x; e.y = y; e.d = d;
    mem_exp_q.push_back(e);
  endtask

  task automatic exp_rd(input logic [XW-1:0] x, input logic [YW-1:0] y);
    mreq_t e;
    e.is_read = 1'b1; e.x = x; e.y = y; e.d = 8'h00;
    mem_exp_q.push_back(e);
  endtask

  task automatic bus_wr(input logic [2:0] sel, input logic [7:0] d);
    @(posedge clock); #1;
    mpuChipSelect = 1'b1; mpuWriteEnable = 1'b0; mpuRegisterSelect = sel; mpuDataIn = d;
    @(posedge clock); #1;
    mpuChipSelect = 1'b0; mpuWriteEnable = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] sel, input logic [7:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clock); #1;
    mpuChipSelect = 1'b1; mpuWriteEnable = 1'b1; mpuRegisterSelect = sel;
    @(posedge clock); #1;
    mpuChipSelect = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((mem_exp_q.size() != 0 || memoryWriteRequest || memoryReadRequest) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, " idle reached"}, 32'(n < 300), 32'd1);
    repeat (2) @(posedge clock);
  endtask

  // Memory model: write acknowledge after wr_lat request cycles, read after one.
  always @(negedge clock) begin
    if (memoryWriteRequest) begin
      wcnt = wcnt + 1;
      memoryWriteComplete = (!stall && wcnt >= wr_lat) || manual_wc;
    end else begin
      wcnt = 0;
      memoryWriteComplete = manual_wc;
    end
    if (memoryReadRequest) begin
      memoryReadComplete = 1'b1;
      memoryReadData = rd_value;
    end else begin
      memoryReadComplete = 1'b0;
    end
  end

  // Monitor: compare MCU reads and new memory requests against the queues.
  always @(negedge clock) begin
    mreq_t act;
    mreq_t exp;
    if (mpuDataOutEnable) begin
      if (rd_exp_q.size() == 0) begin
        check("unexpected mcu read", 32'd1, 32'd0);
      end else begin
        check(rd_name_q.pop_front(), 32'(mpuDataOut), 32'(rd_exp_q.pop_front()));
      end
    end
    if ((memoryWriteRequest && !wr_prev) || (memoryReadRequest && !rd_prev)) begin
      act.is_read = memoryReadRequest;
      act.x = memoryXCoord;
      act.y = memoryYCoord;
      act.d = memoryReadRequest ? 8'h00 : memoryWriteData;
      if (mem_exp_q.size() == 0) begin
        check("unexpected memory request", 32'(act), 32'h0);
      end else begin
        exp = mem_exp_q.pop_front();
        check("memory request {rd,x,y,d}", 32'(act), 32'(exp));
      end
    end
    if (memoryWriteRequest) begin
      wr_hold = wr_hold + 1;
    end else if (wr_prev) begin
      last_hold = wr_hold;
      wr_hold = 0;
    end
    wr_prev = memoryWriteRequest;
    rd_prev = memoryReadRequest;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset wr req", 32'(memoryWriteRequest), 32'd0);
    check("reset rd req", 32'(memoryReadRequest), 32'd0);
    check("reset x", 32'(memoryXCoord), 32'd0);
    check("reset y", 32'(memoryYCoord), 32'd0);
    check("reset wdata", 32'(memoryWriteData), 32'd0);
    check("reset out en", 32'(mpuDataOutEnable), 32'd0);
    check("reset data out", 32'(mpuDataOut), 32'd0);
    reset = 1'b0;
    bus_rd(REG_STATUS, 8'h02, "status after reset");

    // 2: single write, acknowledged after 3 cycles
    wr_lat = 3;
    bus_wr(REG_X_LOW, 8'd5);
    bus_wr(REG_X_HIGH, 8'd0);
    bus_wr(REG_Y, 8'd7);
    exp_wr(9'd5, 8'd7, 8'hAA);
    bus_wr(REG_DATA, 8'hAA);
    wait_idle("single write");
    check("single write hold cycles", 32'(last_hold), 32'd3);
    bus_rd(REG_STATUS, 8'h02, "status after single write");

    // 3: box wrap x 2..3, y 10..11
    wr_lat = 1;
    bus_wr(REG_BOX_CTRL, 8'h01);
    bus_wr(REG_BOX_DATA, 8'd2);
    bus_wr(REG_BOX_DATA, 8'd0);
    bus_wr(REG_BOX_DATA, 8'd3);
    bus_wr(REG_BOX_DATA, 8'd0);
    bus_wr(REG_BOX_DATA, 8'd10);
    bus_wr(REG_BOX_DATA, 8'd11);
    bus_wr(REG_X_LOW, 8'd2);
    bus_wr(REG_Y, 8'd10);
    exp_wr(9'd2, 8'd10, 8'h10);
    exp_wr(9'd3, 8'd10, 8'h11);
    exp_wr(9'd2, 8'd11, 8'h12);
    exp_wr(9'd3, 8'd11, 8'h13);
    exp_wr(9'd2, 8'd10, 8'h14);
    for (int i = 0; i < 5; i++) bus_wr(REG_DATA, 8'(8'h10 + i));
    wait_idle("box wrap");
    bus_rd(REG_STATUS, 8'h0A, "status box enabled");
    bus_rd(REG_X_LOW, 8'd3, "cursor x after box");
    bus_rd(REG_Y, 8'd10, "cursor y after box");

    // 4: overflow with stalled memory
    bus_wr(REG_BOX_CTRL, 8'h00);
    stall = 1'b1;
    bus_wr(REG_X_LOW, 8'd20);
    bus_wr(REG_Y, 8'd30);
    for (int i = 0; i < 4; i++) exp_wr(9'd20, 8'd30, 8'(8'h40 + i));
    for (int i = 0; i < 5; i++) bus_wr(REG_DATA, 8'(8'h40 + i));
    bus_rd(REG_STATUS, 8'h11, "status overflow full");
    bus_rd(REG_STATUS, 8'h01, "status overflow cleared");
    stall = 1'b0;
    wait_idle("overflow drain");
    bus_rd(REG_STATUS, 8'h02, "status after drain");

    // 5: read waits behind posted writes
    wr_lat = 2;
    rd_value = 8'h3C;
    bus_wr(REG_X_LOW, 8'd1);
    bus_wr(REG_Y, 8'd2);
    exp_wr(9'd1, 8'd2, 8'h55);
    exp_wr(9'd1, 8'd2, 8'h66);
    exp_rd(9'd1, 8'd2);
    bus_wr(REG_DATA, 8'h55);
    bus_wr(REG_DATA, 8'h66);
    bus_wr(REG_READ_REQ, 8'h01);
    wait_idle("read ordering");
    bus_rd(REG_STATUS, 8'h06, "status read valid");
    bus_rd(REG_DATA, 8'h3C, "read data");
    bus_rd(REG_STATUS, 8'h02, "status read valid cleared");

    // 6: reset during a write request
    stall = 1'b1;
    exp_wr(9'd1, 8'd2, 8'h77);
    bus_wr(REG_DATA, 8'h77);
    n = 0;
    while (!memoryWriteRequest && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("mid-write request raised", 32'(memoryWriteRequest), 32'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("async drop on reset", 32'(memoryWriteRequest), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    stall = 1'b0;
    manual_wc = 1'b1;
    @(posedge clock); #1;
    manual_wc = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("late complete wr req", 32'(memoryWriteRequest), 32'd0);
    check("late complete rd req", 32'(memoryReadRequest), 32'd0);
    bus_rd(REG_STATUS, 8'h02, "status after mid-write reset");
    bus_rd(REG_X_LOW, 8'd0, "cursor x after reset");
    repeat (2) @(posedge clock);

    check("leftover memory expectations", 32'(mem_exp_q.size()), 32'd0);
    check("leftover read expectations", 32'(rd_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
